line_mem_ctrler: RTL and testbench
==================================

Name: line_mem_ctrler

Overview:
- Responder side of the load/store buffer's memory-controller interface.
- Serves two initiator ports against the single byte-wide RAM/IO bus:
  - cache-line port: whole-line read or write-back;
  - IO byte port: single-byte read/write at or above the IO threshold.
- Serializes each accepted request into byte beats and returns a one-cycle ready pulse.
- Only one request is in flight at a time.

Parameters:
- LINE_BYTES, 16, bytes per cache line (power of 2, at least 2).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes the block
- valid_line  in  1  line request pending
- rw_line  in  1  0 = read line, 1 = write line
- addr_line  in  ADDR_W  line address; low log2(LINE_BYTES) bits ignored
- line_in  in  8*LINE_BYTES  write data; byte k in bits [8k+7:8k]
- ready_line  out  1  one-cycle completion pulse
- line_out  out  8*LINE_BYTES  read data, same byte order
- valid_io  in  1  IO request pending
- rw_io  in  1  0 = read byte, 1 = write byte
- addr_io  in  ADDR_W  IO byte address
- byte_in_io  in  8  IO write data
- ready_io  out  1  one-cycle completion pulse
- byte_out_io  out  8  IO read data
- mem_din  in  8  RAM/IO read data
- mem_dout  out  8  RAM/IO write data
- mem_a  out  ADDR_W  RAM/IO address
- mem_wr  out  1  1 = write beat
- io_buffer_full  in  1  IO sink cannot take a write

Behaviour:
- Reset (rst high at a clock edge):
  - state IDLE;
  - ready_line, ready_io, mem_wr, mem_a, mem_dout, byte_out_io, line_out, beat counter all 0;
  - any in-flight request is abandoned and no ready is issued for it.
- rdy low: every register holds, including mem_wr and mem_a; no beat advances and no ready is issued. Latency stretches by exactly the number of rdy-low cycles.
- Handshake:
  - Initiator holds valid, rw, addr and data stable until it sees ready.
  - ready is registered and high for exactly one cycle.
  - The valid seen in the ready cycle is ignored (stale). Sampling resumes the next cycle, so a request presented with valid held high and rw/addr changed in the ready cycle is accepted one cycle later.
- Arbitration in IDLE: if valid_io and valid_line are both high, IO wins. The losing request waits with its valid held.
- Byte bus timing: mem_din carries the data for the address driven on mem_a in the previous cycle.
- States: IDLE, RD_LINE, WR_LINE, RD_IO, WR_IO, DONE.
- Cycle 0 below is the cycle in which valid is sampled in IDLE.
- RD_LINE:
  - base = addr_line with low bits cleared;
  - mem_wr = 0; mem_a = base+k in cycle k+1, for k = 0..LINE_BYTES-1;
  - byte k is captured from mem_din in cycle k+2;
  - ready_line high in cycle LINE_BYTES+2 with line_out complete.
- WR_LINE:
  - mem_wr = 1, mem_a = base+k, mem_dout = line_in byte k in cycle k+1;
  - mem_wr returns to 0 and ready_line pulses in cycle LINE_BYTES+1.
- RD_IO: mem_a = addr_io in cycle 1; byte captured in cycle 2; ready_io with byte_out_io in cycle 3.
- WR_IO:
  - Waits while io_buffer_full is high; mem_wr stays 0 and mem_a holds addr_io.
  - In the first cycle with io_buffer_full low: mem_wr = 1, mem_dout = byte_in_io.
  - ready_io pulses the next cycle, with mem_wr back to 0.
- DONE: lasts one cycle (the ready cycle), then returns to IDLE.
- Address arithmetic: base+k is computed in ADDR_W bits with no carry into the index bits beyond the line. Wrap at 2^ADDR_W is not handled.
- Outside write beats, mem_wr is 0. mem_a and mem_dout hold their last values.
- line_out and byte_out_io hold until the next capture of the same kind.

Test Plan:
- Line read, addr_line = 0x1234, RAM byte at A = A[7:0]:
  - mem_a = 0x1230..0x123F in cycles 1-16;
  - ready_line only in cycle 18;
  - line_out = 0x3F3E..3130.
- Read then write-back, valid_line held, rw_line = 1 and addr = 0x2000 set in the ready cycle:
  - no beat in the ready cycle; mem_wr = 1 at 0x2000..0x200F in the next 16 cycles;
  - ready_line exactly once, 17 cycles after acceptance.
- IO read, addr_io = 0x30000, mem_din = 0x41 in cycle 2 -> ready_io in cycle 3 with byte_out_io = 0x41.
- IO write 0x30004, byte 0x5A, io_buffer_full high for cycles 0-3:
  - mem_wr stays 0 through cycle 3;
  - mem_wr = 1 with mem_dout = 0x5A in cycle 4;
  - ready_io in cycle 5.
- valid_io and valid_line raised together -> IO completes first; line mem_a beats begin the cycle after the ready_io cycle plus the stale-valid cycle.
- Interruptions:
  - rst in cycle 5 of a line read -> mem_wr = 0 and mem_a = 0 the next cycle, no ready_line ever.
  - rdy low for 4 cycles mid line write -> mem_a/mem_wr frozen, ready_line 4 cycles later than nominal.

Source files
------------

// File: rtl/line_mem_ctrler.sv
// Byte-serial responder for cache-line and IO-byte requests on a single RAM/IO bus.
// One request in flight; each completion is a registered one-cycle ready pulse.
module line_mem_ctrler #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    valid_line,
  input  logic                    rw_line,
  input  logic [ADDR_W-1:0]       addr_line,
  input  logic [8*LINE_BYTES-1:0] line_in,
  output logic                    ready_line,
  output logic [8*LINE_BYTES-1:0] line_out,
  input  logic                    valid_io,
  input  logic                    rw_io,
  input  logic [ADDR_W-1:0]       addr_io,
  input  logic [7:0]              byte_in_io,
  output logic                    ready_io,
  output logic [7:0]              byte_out_io,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  localparam int unsigned OFF = $clog2(LINE_BYTES);
  localparam int unsigned CW  = OFF + 1;
  localparam logic [CW-1:0]     BEATS    = CW'(LINE_BYTES);
  localparam logic [CW-1:0]     RD_LAST  = CW'(LINE_BYTES + 1);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [2:0] {IDLE, RD_LINE, WR_LINE, RD_IO, WR_IO, DONE} state_t;

  state_t                    state_q;
  logic [CW-1:0]             cnt_q;
  logic                      ready_line_q, ready_io_q, mem_wr_q;
  logic [ADDR_W-1:0]         mem_a_q;
  logic [7:0]                mem_dout_q, byte_out_q;
  logic [8*LINE_BYTES-1:0]   line_q;

  logic [OFF-1:0]            beat_idx_d, cap_idx_d;
  logic [ADDR_W-1:0]         line_base_d, beat_addr_d;

  assign beat_idx_d  = cnt_q[OFF-1:0];
  assign cap_idx_d   = OFF'(cnt_q - CW'(2));
  assign line_base_d = addr_line & ~LOW_MASK;
  assign beat_addr_d = line_base_d | ADDR_W'(beat_idx_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ready_line_q <= 1'b0;
      ready_io_q   <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      byte_out_q   <= '0;
      line_q       <= '0;
    end else if (rdy) begin
      ready_line_q <= 1'b0;
      ready_io_q   <= 1'b0;
      mem_wr_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= CW'(1);
          if (valid_io) begin
            mem_a_q <= addr_io;
            if (rw_io) begin
              mem_dout_q <= byte_in_io;
              state_q    <= WR_IO;
            end else begin
              state_q <= RD_IO;
            end
          end else if (valid_line) begin
            mem_a_q <= line_base_d;
            if (rw_line) begin
              mem_wr_q   <= 1'b1;
              mem_dout_q <= line_in[7:0];
              state_q    <= WR_LINE;
            end else begin
              state_q <= RD_LINE;
            end
          end
        end
        // cnt_q tracks the cycle number; captures lag address beats by two cycles.
        RD_LINE: begin
          if (cnt_q < BEATS) mem_a_q <= beat_addr_d;
          if (cnt_q >= CW'(2)) line_q[{cap_idx_d, 3'b000} +: 8] <= mem_din;
          if (cnt_q == RD_LAST) begin
            ready_line_q <= 1'b1;
            state_q      <= DONE;
          end
          cnt_q <= cnt_q + CW'(1);
        end
        WR_LINE: begin
          if (cnt_q < BEATS) begin
            mem_a_q    <= beat_addr_d;
            mem_dout_q <= line_in[{beat_idx_d, 3'b000} +: 8];
            mem_wr_q   <= 1'b1;
            cnt_q      <= cnt_q + CW'(1);
          end else begin
            ready_line_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        RD_IO: begin
          if (cnt_q == CW'(2)) begin
            byte_out_q <= mem_din;
            ready_io_q <= 1'b1;
            state_q    <= DONE;
          end
          cnt_q <= cnt_q + CW'(1);
        end
        WR_IO: begin
          if (!io_buffer_full) begin
            ready_io_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The IO write beat must appear in the same cycle the sink drops full,
  // so that strobe is qualified combinationally; all other beats are registered.
  assign mem_wr      = mem_wr_q | ((state_q == WR_IO) && rdy && !io_buffer_full);
  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  assign ready_line  = ready_line_q;
  assign ready_io    = ready_io_q;
  assign line_out    = line_q;
  assign byte_out_io = byte_out_q;

endmodule

// File: tb/tb_line_mem_ctrler.sv
// Directed plus randomized checks of line_mem_ctrler against a byte-bus RAM model
// and an expected-transaction model derived from request latency/ordering rules.
module tb_line_mem_ctrler;
  localparam int LB = 16;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, rdy;
  logic            valid_line, rw_line, ready_line;
  logic [AW-1:0]   addr_line;
  logic [8*LB-1:0] line_in, line_out;
  logic            valid_io, rw_io, ready_io;
  logic [AW-1:0]   addr_io;
  logic [7:0]      byte_in_io, byte_out_io;
  logic [7:0]      mem_din, mem_dout;
  logic [AW-1:0]   mem_a;
  logic            mem_wr, io_buffer_full;

  line_mem_ctrler #(.LINE_BYTES(LB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .valid_line(valid_line), .rw_line(rw_line), .addr_line(addr_line),
    .line_in(line_in), .ready_line(ready_line), .line_out(line_out),
    .valid_io(valid_io), .rw_io(rw_io), .addr_io(addr_io),
    .byte_in_io(byte_in_io), .ready_io(ready_io), .byte_out_io(byte_out_io),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // Bench-owned RAM contents: preloaded bytes, otherwise A[7:0].
  logic [7:0]  pre [logic [31:0]];
  logic [39:0] wlog [$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [7:0] ram_rd(logic [31:0] a);
    if (pre.exists(a)) return pre[a];
    return a[7:0];
  endfunction

  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (rdy && !rst && mem_wr) wlog.push_back({mem_a, mem_dout});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_line(logic [31:0] a);
    logic [127:0] r;
    logic [31:0]  b;
    b = {a[31:4], 4'h0};
    for (int k = 0; k < LB; k++) r[8*k +: 8] = ram_rd(b + 32'(k));
    return r;
  endfunction

  task automatic check_line_writes(string tag, logic [31:0] a, logic [127:0] d);
    logic [31:0] b;
    b = {a[31:4], 4'h0};
    check({tag, "_nwr"}, 128'(wlog.size()), 128'(LB));
    for (int k = 0; k < LB && k < wlog.size(); k++)
      check({tag, "_wr"}, 128'(wlog[k]), 128'({b + 32'(k), d[8*k +: 8]}));
  endtask

  // Issue one request, hold it until ready (bounded), check latency and data.
  task automatic run_req(string tag, bit is_io, bit rw, logic [31:0] a,
                         logic [127:0] d, int nfull, int exp_lat);
    int lat;
    bit got;
    wlog.delete();
    if (is_io) begin
      valid_io = 1'b1; rw_io = rw; addr_io = a; byte_in_io = d[7:0];
      io_buffer_full = (nfull > 0);
    end else begin
      valid_line = 1'b1; rw_line = rw; addr_line = a; line_in = d;
    end
    lat = 0; got = 1'b0;
    for (int c = 1; c <= 100 && !got; c++) begin
      tick();
      if (is_io) begin
        io_buffer_full = (c < nfull);
        #1;
      end
      if (is_io ? ready_io : ready_line) begin
        got = 1'b1;
        lat = c;
      end
    end
    check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    if (is_io && !rw) check({tag, "_byte"}, 128'(byte_out_io), 128'(ram_rd(a)));
    if (is_io && rw) begin
      check({tag, "_nwr"}, 128'(wlog.size()), 128'd1);
      if (wlog.size() > 0) check({tag, "_wr"}, 128'(wlog[0]), 128'({a, d[7:0]}));
    end
    if (!is_io && !rw) check({tag, "_line"}, line_out, exp_line(a));
    if (!is_io && rw) check_line_writes(tag, a, d);
    valid_io = 1'b0; valid_line = 1'b0; io_buffer_full = 1'b0;
    tick();
  endtask

  initial begin
    logic [127:0] d;
    logic [31:0]  a;
    int           nr, nf, op;
    rst = 1'b1; rdy = 1'b1;
    valid_line = 1'b0; rw_line = 1'b0; addr_line = '0; line_in = '0;
    valid_io = 1'b0; rw_io = 1'b0; addr_io = '0; byte_in_io = '0;
    io_buffer_full = 1'b0;
    tick(); tick();
    check("rst_ready_line", 128'(ready_line), 128'd0);
    check("rst_ready_io", 128'(ready_io), 128'd0);
    check("rst_mem_wr", 128'(mem_wr), 128'd0);
    check("rst_mem_a", 128'(mem_a), 128'd0);
    check("rst_mem_dout", 128'(mem_dout), 128'd0);
    check("rst_byte_out", 128'(byte_out_io), 128'd0);
    check("rst_line_out", line_out, 128'd0);
    rst = 1'b0;
    tick();

    // Line read at 0x1234, then write-back to 0x2000 presented in the ready cycle.
    valid_line = 1'b1; rw_line = 1'b0; addr_line = 32'h1234;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c <= 16) check("rd_mem_a", 128'(mem_a), 128'(32'h1230 + 32'(c - 1)));
      check("rd_mem_wr", 128'(mem_wr), 128'd0);
      check("rd_ready", 128'(ready_line), 128'(c == 18));
    end
    check("rd_line", line_out, 128'h3F3E3D3C3B3A39383736353433323130);
    d = {$urandom, $urandom, $urandom, $urandom};
    rw_line = 1'b1; addr_line = 32'h2000; line_in = d;
    wlog.delete();
    nr = 0;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 1) check("wb_no_beat", 128'(mem_wr), 128'd0);
      if (ready_line) nr++;
      if (c == 18) check("wb_ready_at_17", 128'(ready_line), 128'd1);
    end
    check("wb_ready_once", 128'(nr), 128'd1);
    check_line_writes("wb", 32'h2000, d);
    valid_line = 1'b0;
    tick();

    pre[32'h30000] = 8'h41;
    run_req("io_rd", 1'b1, 1'b0, 32'h30000, 128'h0, 0, 3);
    run_req("io_wr", 1'b1, 1'b1, 32'h30004, 128'h5A, 4, 5);

    // Simultaneous IO and line requests: IO first, line beats start in cycle 5.
    valid_io = 1'b1; rw_io = 1'b0; addr_io = 32'h30010;
    valid_line = 1'b1; rw_line = 1'b0; addr_line = 32'h4000;
    nr = 0;
    for (int c = 1; c <= 40 && nr == 0; c++) begin
      tick();
      if (c == 3) begin
        check("arb_io_first", 128'({ready_io, ready_line}), 128'b10);
        check("arb_io_byte", 128'(byte_out_io), 128'(ram_rd(32'h30010)));
        valid_io = 1'b0;
      end
      if (c == 5) check("arb_line_start", 128'(mem_a), 128'h4000);
      if (ready_line) nr = c;
    end
    check("arb_line_lat", 128'(nr), 128'd22);
    check("arb_line_data", line_out, exp_line(32'h4000));
    valid_line = 1'b0;
    tick();

    // Reset in cycle 5 of a line read abandons it.
    valid_line = 1'b1; rw_line = 1'b0; addr_line = 32'h5000;
    for (int c = 1; c <= 5; c++) tick();
    rst = 1'b1; valid_line = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_mid_wr", 128'(mem_wr), 128'd0);
    check("rst_mid_a", 128'(mem_a), 128'd0);
    nr = 0;
    for (int c = 0; c < 30; c++) begin
      if (ready_line) nr++;
      tick();
    end
    check("rst_mid_no_ready", 128'(nr), 128'd0);

    // rdy low for cycles 6..9 of a line write.
    d = {$urandom, $urandom, $urandom, $urandom};
    wlog.delete();
    valid_line = 1'b1; rw_line = 1'b1; addr_line = 32'h6000; line_in = d;
    nr = 0;
    for (int c = 1; c <= 40 && nr == 0; c++) begin
      tick();
      if (c == 6) rdy = 1'b0;
      if (c == 10) rdy = 1'b1;
      if (c >= 6 && c <= 10) begin
        check("frz_mem_a", 128'(mem_a), 128'h6005);
        check("frz_mem_wr", 128'(mem_wr), 128'd1);
      end
      if (ready_line) nr = c;
    end
    check("frz_lat", 128'(nr), 128'd21);
    check_line_writes("frz", 32'h6000, d);
    valid_line = 1'b0;
    tick();

    // Randomized mix of request kinds.
    for (int i = 0; i < 12; i++) begin
      op = $urandom_range(0, 3);
      d  = {$urandom, $urandom, $urandom, $urandom};
      nf = $urandom_range(0, 4);
      case (op)
        0: begin a = $urandom & 32'h0FFF_FFFF; run_req("rnd_lrd", 1'b0, 1'b0, a, d, 0, LB + 2); end
        1: begin a = $urandom & 32'h0FFF_FFFF; run_req("rnd_lwr", 1'b0, 1'b1, a, d, 0, LB + 1); end
        2: begin a = 32'h30000 + ($urandom & 32'hFFF); run_req("rnd_iord", 1'b1, 1'b0, a, d, 0, 3); end
        default: begin
          a = 32'h30000 + ($urandom & 32'hFFF);
          run_req("rnd_iowr", 1'b1, 1'b1, a, d, nf, ((nf > 1) ? nf : 1) + 1);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
